// File: rtl/cntr8_fsm_pkg.sv
// rtl/cntr8_fsm_pkg.sv - state codes, operand constants and the clb4 carry helper
package cntr8_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_INC  = 3'b010,
    ST_INC2 = 3'b011,
    ST_DEC  = 3'b100,
    ST_DEC2 = 3'b101
  } state_t;

  localparam logic [7:0] OPND_INC = 8'h01;
  localparam logic [7:0] OPND_DEC = 8'hFF;
  localparam logic [7:0] CNT_RST  = 8'h00;

  // clb4: 4-bit carry-lookahead block, returns carries out of bits 0..3
  function automatic logic [3:0] clb4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

endpackage

// File: rtl/cntr8_fsm_cla8.sv
// rtl/cntr8_fsm_cla8.sv - 8-bit carry-lookahead adder from two clb4 slices
module cla8
  import cntr8_fsm_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] g;
  logic [7:0] p;
  logic [3:0] c_lo;
  logic [3:0] c_hi;

  assign g = a & b;
  assign p = a ^ b;

  // upper slice takes its carry-in from the lower slice's lookahead carry
  assign c_lo = clb4(g[3:0], p[3:0], ci);
  assign c_hi = clb4(g[7:4], p[7:4], c_lo[3]);

  assign s  = p ^ {c_hi[2:0], c_lo[3], c_lo[2:0], ci};
  assign co = c_hi[3];

endmodule

// File: rtl/cntr8_fsm.sv
// rtl/cntr8_fsm.sv - registered 8-bit loadable up/down counter with 6-state FSM
module cntr8_fsm
  import cntr8_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic [2:0] o_state
);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] opnd;
  logic [7:0] sum;
  logic       unused_co;

  assign opnd = inc ? OPND_INC : OPND_DEC;

  cla8 u_cla8 (
    .a  (cnt_q),
    .b  (opnd),
    .ci (1'b0),
    .s  (sum),
    .co (unused_co)
  );

  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = CNT_RST;
    // illegal codes recover to IDLE with a cleared count, regardless of inputs
    if (state_q == 3'b110 || state_q == 3'b111) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = ST_LOAD;
    end else if (inc) begin
      state_d = (state_q == ST_INC) ? ST_INC2 : ST_INC;
    end else begin
      state_d = (state_q == ST_DEC) ? ST_DEC2 : ST_DEC;
    end

    case (state_d)
      ST_LOAD:                          cnt_d = d_in;
      ST_INC, ST_INC2, ST_DEC, ST_DEC2: cnt_d = sum;
      default:                          cnt_d = CNT_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_out   = cnt_q;
  assign o_state = state_q;

endmodule
